// File: rtl/cam_pixel_capture.sv
// Camera byte-stream to 16-bit pixel writer for a dual-port frame buffer.
// Define CAM_TEST_PATTERN_EN to write the pixel address as data instead of camera bytes.
module cam_pixel_capture #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  px_data,
    output logic [16:0] mem_px_addr,
    output logic [15:0] mem_px_data,
    output logic        px_wr,
    output logic        frame_done,
    output logic        frame_ovf
);

    localparam int unsigned NPIX      = IMG_W * IMG_H;
    localparam logic [16:0] LAST_ADDR = 17'(NPIX - 1);

    typedef enum logic [1:0] {WAIT_SYNC, WAIT_START, BYTE_HI, BYTE_LO} state_t;

    state_t      r_state;
    logic [7:0]  r_hi;
    logic [16:0] r_addr;
    logic [15:0] r_data;
    logic        r_wr;
    logic        r_done;
    logic        r_ovf;
    logic        r_full;
    logic [15:0] w_pixel;

`ifdef CAM_TEST_PATTERN_EN
    assign w_pixel = r_addr[15:0];
`else
    assign w_pixel = {r_hi, px_data};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_SYNC;
            r_hi    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wr    <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            // Address advances after the write cycle; the last slot latches r_full instead.
            if (r_wr) begin
                if (r_addr == LAST_ADDR) r_full <= 1'b1;
                else                     r_addr <= r_addr + 17'd1;
            end
            case (r_state)
                WAIT_SYNC: begin
                    if (vsync) r_state <= WAIT_START;
                end
                WAIT_START: begin
                    if (!vsync) begin
                        r_state <= BYTE_HI;
                        r_addr  <= '0;
                        r_ovf   <= 1'b0;
                        r_full  <= 1'b0;
                    end
                end
                BYTE_HI: begin
                    if (vsync) begin
                        r_done  <= 1'b1;
                        r_state <= WAIT_START;
                    end else if (href) begin
                        r_hi    <= px_data;
                        r_state <= BYTE_LO;
                    end
                end
                BYTE_LO: begin
                    if (vsync) begin
                        r_done  <= 1'b1;
                        r_state <= WAIT_START;
                    end else begin
                        r_state <= BYTE_HI;
                        if (href) begin
                            if (r_full) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_wr   <= 1'b1;
                                r_data <= w_pixel;
                            end
                        end
                    end
                end
                default: r_state <= WAIT_SYNC;
            endcase
        end
    end

    assign mem_px_addr = r_addr;
    assign mem_px_data = r_data;
    assign px_wr       = r_wr;
    assign frame_done  = r_done;
    assign frame_ovf   = r_ovf;

endmodule
